// File: rtl/tb_wait_duration_multi.sv
// Multi-channel wait-duration timer for the testbench event library.
//
// NB_CH independent channels. Each one is started with a duration and a unit
// (cycles / us / ms) and then waits D*P clock cycles, where P is the prescale
// for the unit. Scenario sequencers use the per-channel done pulses, or the
// global all-done pulse, to block until waits complete.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_start      per-channel start strobe (1-cycle pulse)
//   i_abort      per-channel abort strobe (wins over a same-cycle start)
//   i_duration   channel c duration at [c*CNT_W +: CNT_W], unsigned
//   i_unit       channel c unit at [c*2 +: 2]: 00 cycles, 01 us, 10 ms, 11 illegal
//   o_busy       channel is waiting
//   o_done       1-cycle pulse, wait completed
//   o_err        1-cycle pulse, start with illegal unit
//   o_all_done   1-cycle pulse, last running channel completed
module tb_wait_duration_multi #(
  parameter int unsigned NB_CH = 4,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PS_US = 100,
  parameter int unsigned PS_MS = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NB_CH-1:0]       i_start,
  input  logic [NB_CH-1:0]       i_abort,
  input  logic [NB_CH*CNT_W-1:0] i_duration,
  input  logic [NB_CH*2-1:0]     i_unit,
  output logic [NB_CH-1:0]       o_busy,
  output logic [NB_CH-1:0]       o_done,
  output logic [NB_CH-1:0]       o_err,
  output logic                   o_all_done
);

  // Sub-counter holds at most PS_MS-1.
  localparam int unsigned SUB_W = (PS_MS > 1) ? $clog2(PS_MS) : 1;

  typedef enum logic {StIdle, StRun} state_e;

  // Sub-counter reload value (P-1) for a legal unit.
  function automatic logic [SUB_W-1:0] reload_of(input logic [1:0] unit);
    logic [SUB_W-1:0] r;
    case (unit)
      2'b01:   r = SUB_W'(PS_US - 1);
      2'b10:   r = SUB_W'(PS_MS - 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  state_e           state_q [NB_CH];
  state_e           state_d [NB_CH];
  logic [SUB_W-1:0] sub_q   [NB_CH];
  logic [SUB_W-1:0] sub_d   [NB_CH];
  logic [SUB_W-1:0] pre_q   [NB_CH];
  logic [SUB_W-1:0] pre_d   [NB_CH];
  logic [CNT_W-1:0] main_q  [NB_CH];
  logic [CNT_W-1:0] main_d  [NB_CH];

  // pend marks a zero-duration start whose done goes out one edge later.
  logic [NB_CH-1:0] pend_q, pend_d;
  logic [NB_CH-1:0] done_q, done_d;
  logic [NB_CH-1:0] err_q, err_d;
  logic [NB_CH-1:0] run_now, run_next;
  logic             all_done_q, all_done_d;

  always_comb begin
    for (int c = 0; c < NB_CH; c++) begin
      state_d[c] = state_q[c];
      sub_d[c]   = sub_q[c];
      pre_d[c]   = pre_q[c];
      main_d[c]  = main_q[c];
      pend_d[c]  = 1'b0;
      err_d[c]   = 1'b0;
      done_d[c]  = pend_q[c];

      // Count down: sub-counter P-1..0, main counter steps on sub wrap.
      // main_q is never 0 while running, so reaching 1 at a wrap ends the wait.
      if (state_q[c] == StRun) begin
        if (sub_q[c] != '0) begin
          sub_d[c] = sub_q[c] - 1'b1;
        end else if (main_q[c] == CNT_W'(1)) begin
          state_d[c] = StIdle;
          done_d[c]  = 1'b1;
        end else begin
          main_d[c] = main_q[c] - 1'b1;
          sub_d[c]  = pre_q[c];
        end
      end

      if (i_abort[c]) begin
        // Abort discards any same-cycle start; ignored when idle.
        if (state_q[c] == StRun) begin
          state_d[c] = StIdle;
          done_d[c]  = pend_q[c];
        end
      end else if (i_start[c]) begin
        if (i_unit[c*2 +: 2] == 2'b11) begin
          // Illegal unit: flag it, leave the channel untouched.
          err_d[c] = 1'b1;
        end else begin
          // Restart suppresses a completion landing on this same edge.
          done_d[c] = pend_q[c];
          if (i_duration[c*CNT_W +: CNT_W] == '0) begin
            state_d[c] = StIdle;
            pend_d[c]  = 1'b1;
          end else begin
            state_d[c] = StRun;
            main_d[c]  = i_duration[c*CNT_W +: CNT_W];
            sub_d[c]   = reload_of(i_unit[c*2 +: 2]);
            pre_d[c]   = reload_of(i_unit[c*2 +: 2]);
          end
        end
      end

      run_now[c]  = (state_q[c] == StRun);
      run_next[c] = (state_d[c] == StRun);
    end

    all_done_d = (|run_now) && !(|run_next) && (|done_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NB_CH; c++) begin
        state_q[c] <= StIdle;
        sub_q[c]   <= '0;
        pre_q[c]   <= '0;
        main_q[c]  <= '0;
      end
      pend_q     <= '0;
      done_q     <= '0;
      err_q      <= '0;
      all_done_q <= 1'b0;
    end else begin
      for (int c = 0; c < NB_CH; c++) begin
        state_q[c] <= state_d[c];
        sub_q[c]   <= sub_d[c];
        pre_q[c]   <= pre_d[c];
        main_q[c]  <= main_d[c];
      end
      pend_q     <= pend_d;
      done_q     <= done_d;
      err_q      <= err_d;
      all_done_q <= all_done_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NB_CH; c++) begin
      o_busy[c] = (state_q[c] == StRun);
    end
  end

  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_all_done = all_done_q;

endmodule
